// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared constants, state type and predictor for the PRBS-26 checker
package prbs_pkg;

  localparam int N_LFSR = 26;
  // Selects hist[25], hist[24], hist[23], hist[19]: s[n]=s[n-26]^s[n-25]^s[n-24]^s[n-20]
  localparam logic [N_LFSR-1:0] TAP_MASK = 26'h3880000;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    LOST    = 2'd2
  } prbs_state_t;

  function automatic logic predict(input logic [N_LFSR-1:0] h);
    return ^(h & TAP_MASK);
  endfunction

endpackage

// File: rtl/prbs_checker_err_window.sv
// rtl/prbs_checker_err_window.sv - windowed mismatch counter that flags loss of lock
module prbs_err_window #(
  parameter int WIN    = 64,
  parameter int THRESH = 8
) (
  input  logic clk,
  input  logic r_n,
  input  logic clear,
  input  logic step,
  input  logic mismatch,
  output logic lose
);

  localparam int WB = $clog2(WIN);
  localparam int EB = $clog2(WIN + 1);

  logic [WB-1:0] wbits;
  logic [EB-1:0] werr;
  logic [EB-1:0] werr_sum;

  assign werr_sum = werr + EB'(mismatch);
  // The wrap bit itself still counts toward this window before both counters clear
  assign lose     = step && (werr_sum >= EB'(THRESH));

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      wbits <= '0;
      werr  <= '0;
    end else if (clear) begin
      wbits <= '0;
      werr  <= '0;
    end else if (step) begin
      if (wbits == WB'(WIN - 1)) begin
        wbits <= '0;
        werr  <= '0;
      end else begin
        wbits <= wbits + 1'b1;
        werr  <= werr_sum;
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising checker for the x^26+x^6+x^2+x+1 pattern stream
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int N      = N_LFSR,
  parameter int CW     = 16,
  parameter int WIN    = 64,
  parameter int THRESH = 8
) (
  input  logic          clk,
  input  logic          r_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] bit_count
);

  localparam int FB = $clog2(N + 1);

  prbs_state_t   state, state_nxt;
  logic [N-1:0]  hist;
  logic [N-1:0]  hist_in;
  logic [FB-1:0] fill;
  logic [FB-1:0] fill_inc;
  logic          accept, step, exp_bit, mismatch, acq_ok, lose;

  assign accept   = in_valid && !clr;
  assign exp_bit  = predict(hist);
  assign mismatch = in_bit ^ exp_bit;
  assign step     = accept && (state == LOCKED);
  // Once locked the reference free-runs, so a line error never propagates into hist
  assign hist_in  = {hist[N-2:0], (state == LOCKED) ? exp_bit : in_bit};
  assign fill_inc = (fill == FB'(N)) ? fill : fill + 1'b1;
  assign acq_ok   = (fill_inc == FB'(N)) && (hist_in != '0);

  prbs_err_window #(
    .WIN    (WIN),
    .THRESH (THRESH)
  ) u_err_window (
    .clk      (clk),
    .r_n      (r_n),
    .clear    (clr || (state != LOCKED)),
    .step     (step),
    .mismatch (mismatch),
    .lose     (lose)
  );

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) state <= ACQUIRE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACQUIRE;
    end else begin
      case (state)
        ACQUIRE: if (accept && acq_ok) state_nxt = LOCKED;
        LOCKED:  if (lose)             state_nxt = LOST;
        LOST:                          state_nxt = ACQUIRE;
        default:                       state_nxt = ACQUIRE;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      hist      <= '0;
      fill      <= '0;
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      if (accept) hist <= hist_in;
      if (clr || state == LOST)          fill <= '0;
      else if (accept && state == ACQUIRE) fill <= fill_inc;
      err <= step && mismatch;
      if (clr) begin
        err_count <= '0;
        bit_count <= '0;
      end else if (step) begin
        if (bit_count != '1)             bit_count <= bit_count + 1'b1;
        if (mismatch && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed bench for prbs_checker driven by a Galois generator model
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        r_n, clr, in_valid, in_bit;
  logic        locked, err, locked4, err4;
  logic [15:0] err_count, bit_count;
  logic [3:0]  err_count4, bit_count4;
  logic [25:0] gq;
  int          nvec = 0;
  int          nmis = 0;

  always #5 clk = ~clk;

  prbs_checker #(.CW(16)) dut (
    .clk(clk), .r_n(r_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .locked(locked), .err(err), .err_count(err_count), .bit_count(bit_count)
  );

  prbs_checker #(.CW(4)) dut4 (
    .clk(clk), .r_n(r_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .locked(locked4), .err(err4), .err_count(err_count4), .bit_count(bit_count4)
  );

  task automatic gen(output logic b);
    b  = gq[25];
    gq = {gq[24:0], 1'b0} ^ (gq[25] ? 26'h0000047 : 26'h0000000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nvec++;
    assert (obs === want) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic send(input logic flip);
    logic b;
    gen(b);
    in_valid = 1'b1;
    in_bit   = b ^ flip;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_bit   = 1'($urandom);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    r_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; gq = 26'h0000001;
    tick(); tick();
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_err_count4", err_count4, 0);
    r_n = 1'b1;

    // Clean stream: first 25 bits are zero, lock after bit 26
    for (int i = 1; i <= 300; i++) begin
      send(1'b0);
      chk("p1_locked", locked, (i >= 26));
      chk("p1_err", err, 0);
    end
    chk("p1_bit_count", bit_count, 274);
    chk("p1_err_count", err_count, 0);

    // Single inverted bit
    repeat (40) send(1'b0);
    send(1'b1);
    chk("p2_err_pulse", err, 1);
    chk("p2_err_count", err_count, 1);
    chk("p2_locked", locked, 1);
    for (int i = 0; i < 30; i++) begin
      send(1'b0);
      chk("p2_no_mult", err, 0);
    end
    chk("p2_err_count_after", err_count, 1);
    chk("p2_bit_count", bit_count, 345);

    // Eight errors inside one window (wbits 25..32) force loss
    for (int i = 1; i <= 8; i++) begin
      send(1'b1);
      chk("p3_err", err, 1);
      chk("p3_locked", locked, (i < 8));
    end
    chk("p3_err_count", err_count, 9);
    chk("p3_bit_count", bit_count, 353);
    send(1'b0);
    chk("p3_lost", locked, 0);
    for (int i = 1; i <= 26; i++) begin
      send(1'b0);
      chk("p3_relock", locked, (i == 26));
    end
    chk("p3_frozen_err", err_count, 9);
    chk("p3_frozen_bits", bit_count, 353);

    // 7 errors at the end of one window, 7 at the start of the next
    repeat (57) send(1'b0);
    for (int i = 0; i < 14; i++) begin
      send(1'b1);
      chk("p4_err", err, 1);
      chk("p4_locked", locked, 1);
    end
    repeat (20) send(1'b0);
    chk("p4_locked_end", locked, 1);
    chk("p4_err_count", err_count, 23);
    chk("p4_bit_count", bit_count, 444);

    // Async reset mid-stream, then all-zero input must not lock
    #2;
    r_n = 1'b0;
    #1;
    chk("p5_async_locked", locked, 0);
    chk("p5_async_err_count", err_count, 0);
    chk("p5_async_bit_count", bit_count, 0);
    tick();
    r_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b0;
      tick();
      chk("p5_zero_locked", locked, 0);
    end
    gq = 26'h0000001;
    for (int i = 1; i <= 26; i++) begin
      send(1'b0);
      chk("p5_lock", locked, (i == 26));
    end
    repeat (10) send(1'b0);
    chk("p5_bit_count", bit_count, 10);
    chk("p5_err_count", err_count, 0);

    // Random valid gaps hold state
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) begin
        idle();
        chk("p6_gap_locked", locked, 1);
        chk("p6_gap_err", err, 0);
      end
      send(1'b0);
      chk("p6_locked", locked, 1);
      chk("p6_err", err, 0);
    end
    send(1'b1);
    chk("p6_err_pulse", err, 1);
    chk("p6_err_count", err_count, 1);
    chk("p6_bit_count", bit_count, 41);
    idle();
    chk("p6_err_idle", err, 0);
    chk("p6_bit_hold", bit_count, 41);

    // Clear dominates a valid bit
    clr = 1'b1; in_valid = 1'b1; in_bit = 1'($urandom);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("p6_clr_locked", locked, 0);
    chk("p6_clr_err", err, 0);
    chk("p6_clr_err_count", err_count, 0);
    chk("p6_clr_bit_count", bit_count, 0);
    chk("p6_clr_err_count4", err_count4, 0);
    for (int i = 1; i <= 26; i++) begin
      send(1'b0);
      chk("p6_relock", locked, (i == 26));
    end

    // One error every 16 bits: 4 per window, enough to saturate the 4-bit counters
    for (int i = 1; i <= 256; i++) send(i % 16 == 0);
    chk("p7_locked", locked, 1);
    chk("p7_locked4", locked4, 1);
    chk("p7_err_count", err_count, 16);
    chk("p7_bit_count", bit_count, 256);
    chk("p7_err_count4_sat", err_count4, 15);
    chk("p7_bit_count4_sat", bit_count4, 15);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
